fu_output_queue: RTL and testbench

Parametrised result-output stage for a functional unit. It sits between the FU datapath and the two shared result buses: the common data bus (CDB) and the reorder-buffer (ROB) write port. Each result is held in a DEPTH-entry queue with independent CDB and ROB drain pointers, so the FU keeps issuing while either bus is contended. Bus arbitration is a daisy chain: a higher-priority upstream unit raises `*_transmit`, and this block ORs in its own request and forwards it downstream.

---
 rtl/fu_output_queue.sv | 157 +++++++++++++++
 tb/tb_fu_output_queue.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fu_output_queue.sv
// Result output queue for a functional unit: one queue, separate CDB and ROB drain pointers,
// daisy-chained bus requests. Define FU_OUT_BYPASS_EN for same-cycle input pass-through.
module fu_output_queue #(
  parameter int DATA_W  = 8,
  parameter int TAG_W   = 4,
  parameter int ROBID_W = 4,
  parameter int FLAGS_W = 8,
  parameter int WBS_W   = 8,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  input  logic               in_cdb_en,
  input  logic [WBS_W-1:0]   in_wbs,
  input  logic [FLAGS_W-1:0] in_flags,
  input  logic [ROBID_W-1:0] in_robid,
  input  logic [DATA_W-1:0]  in_result,
  output logic               in_ready,
  input  logic               cdb_transmit,
  output logic               cdb_transmit_out,
  output logic [TAG_W-1:0]   cdb_id,
  output logic [DATA_W-1:0]  cdb_val,
  input  logic               rob_transmit,
  output logic               rob_transmit_out,
  output logic [ROBID_W-1:0] robid_out,
  output logic [FLAGS_W-1:0] flags_out,
  output logic [WBS_W-1:0]   wbs_out,
  output logic [DATA_W-1:0]  value_out,
  output logic               busy,
  output logic               overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_V = DEPTH[PW:0];

  logic [PW:0] wr_q, wr_d, cdb_q, cdb_d, rob_q, rob_d;
  logic        ovf_q, ovf_d;

  logic               st_en_q    [DEPTH];
  logic [WBS_W-1:0]   st_wbs_q   [DEPTH];
  logic [FLAGS_W-1:0] st_flags_q [DEPTH];
  logic [ROBID_W-1:0] st_robid_q [DEPTH];
  logic [DATA_W-1:0]  st_res_q   [DEPTH];

  logic [PW-1:0] wr_idx, cdb_idx, rob_idx;
  logic [PW:0]   occ_cdb, occ_rob, occ;
  logic          accept;
  logic          rob_pend, rob_byp, rob_request, rob_grant;
  logic          cdb_pend, cdb_head_en, cdb_skip, cdb_byp, cdb_byp_skip;
  logic          cdb_request, cdb_grant, cdb_adv;
  logic [WBS_W-1:0]   cdb_wbs_sel;
  logic [DATA_W-1:0]  cdb_val_sel;

  assign wr_idx  = wr_q[PW-1:0];
  assign cdb_idx = cdb_q[PW-1:0];
  assign rob_idx = rob_q[PW-1:0];

  // Occupancy is set by whichever channel lags; same-cycle retirement earns no credit.
  assign occ_cdb  = wr_q - cdb_q;
  assign occ_rob  = wr_q - rob_q;
  assign occ      = (occ_cdb > occ_rob) ? occ_cdb : occ_rob;
  assign in_ready = occ < DEPTH_V;
  assign accept   = in_valid & in_ready & ~flush;

  assign rob_pend    = rob_q != wr_q;
  assign cdb_pend    = cdb_q != wr_q;
  assign cdb_head_en = st_en_q[cdb_idx];
  assign cdb_skip    = cdb_pend & ~cdb_head_en;

`ifdef FU_OUT_BYPASS_EN
  assign rob_byp      = accept & ~rob_pend;
  assign cdb_byp      = accept & in_cdb_en & ~cdb_pend;
  assign cdb_byp_skip = accept & ~in_cdb_en & ~cdb_pend;
`else
  assign rob_byp      = 1'b0;
  assign cdb_byp      = 1'b0;
  assign cdb_byp_skip = 1'b0;
`endif

  assign rob_request = rob_pend | rob_byp;
  assign rob_grant   = rob_request & ~rob_transmit;
  assign cdb_request = (cdb_pend & cdb_head_en) | cdb_byp;
  assign cdb_grant   = cdb_request & ~cdb_transmit;
  assign cdb_adv     = cdb_grant | cdb_skip | cdb_byp_skip;

  assign rob_transmit_out = rob_transmit | rob_request;
  assign cdb_transmit_out = cdb_transmit | cdb_request;

  // Payloads are zero when not granted so the shared buses can be OR-combined.
  always_comb begin
    robid_out = '0;
    flags_out = '0;
    wbs_out   = '0;
    value_out = '0;
    if (rob_grant) begin
      if (rob_pend) begin
        robid_out = st_robid_q[rob_idx];
        flags_out = st_flags_q[rob_idx];
        wbs_out   = st_wbs_q[rob_idx];
        value_out = st_res_q[rob_idx];
      end else begin
        robid_out = in_robid;
        flags_out = in_flags;
        wbs_out   = in_wbs;
        value_out = in_result;
      end
    end
  end

  assign cdb_wbs_sel = cdb_pend ? st_wbs_q[cdb_idx] : in_wbs;
  assign cdb_val_sel = cdb_pend ? st_res_q[cdb_idx] : in_result;
  assign cdb_id      = cdb_grant ? cdb_wbs_sel[TAG_W-1:0] : '0;
  assign cdb_val     = cdb_grant ? cdb_val_sel : '0;

  assign busy     = rob_pend | cdb_pend | in_valid;
  assign overflow = ovf_q;

  always_comb begin
    wr_d  = wr_q + {{PW{1'b0}}, accept};
    rob_d = rob_q + {{PW{1'b0}}, rob_grant};
    cdb_d = cdb_q + {{PW{1'b0}}, cdb_adv};
    ovf_d = ovf_q | (in_valid & ~in_ready & ~flush);
    if (flush) begin
      wr_d  = wr_q;
      rob_d = wr_q;
      cdb_d = wr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rob_q <= '0;
      cdb_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rob_q <= rob_d;
      cdb_q <= cdb_d;
      ovf_q <= ovf_d;
    end
  end

  // Entry contents need no reset: they are only observed once a pointer says they are valid.
  always_ff @(posedge clk) begin
    if (accept) begin
      st_en_q[wr_idx]    <= in_cdb_en;
      st_wbs_q[wr_idx]   <= in_wbs;
      st_flags_q[wr_idx] <= in_flags;
      st_robid_q[wr_idx] <= in_robid;
      st_res_q[wr_idx]   <= in_result;
    end
  end

endmodule

// File: tb/tb_fu_output_queue.sv
// Scoreboard bench for fu_output_queue: stimulus pushes expected bus traffic,
// a negedge monitor pops and compares every CDB/ROB grant.
module tb_fu_output_queue;

`ifdef FU_OUT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, flush, in_valid, in_cdb_en;
  logic [7:0] in_wbs, in_flags, in_result;
  logic [3:0] in_robid;
  logic       in_ready;
  logic       cdb_transmit, cdb_transmit_out;
  logic [3:0] cdb_id;
  logic [7:0] cdb_val;
  logic       rob_transmit, rob_transmit_out;
  logic [3:0] robid_out;
  logic [7:0] flags_out, wbs_out, value_out;
  logic       busy, overflow;

  int total = 0;
  int bad   = 0;

  logic [27:0] rob_sb [$];
  logic [11:0] cdb_sb [$];

  always #5 clk = ~clk;

  fu_output_queue dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_cdb_en(in_cdb_en),
    .in_wbs(in_wbs), .in_flags(in_flags), .in_robid(in_robid), .in_result(in_result),
    .in_ready(in_ready),
    .cdb_transmit(cdb_transmit), .cdb_transmit_out(cdb_transmit_out),
    .cdb_id(cdb_id), .cdb_val(cdb_val),
    .rob_transmit(rob_transmit), .rob_transmit_out(rob_transmit_out),
    .robid_out(robid_out), .flags_out(flags_out), .wbs_out(wbs_out), .value_out(value_out),
    .busy(busy), .overflow(overflow)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic put(input logic en, input logic [7:0] wbs, input logic [7:0] flg,
                     input logic [3:0] rid, input logic [7:0] res, input bit pr, input bit pc);
    in_valid  = 1'b1;
    in_cdb_en = en;
    in_wbs    = wbs;
    in_flags  = flg;
    in_robid  = rid;
    in_result = res;
    if (pr) rob_sb.push_back({rid, flg, wbs, res});
    if (pc) cdb_sb.push_back({wbs[3:0], res});
  endtask

  // Monitor: every granted beat must match the scoreboard head; idle buses must read zero.
  always @(negedge clk) begin
    logic [27:0] re;
    logic [11:0] ce;
    if (!rst) begin
      if (rob_transmit_out && !rob_transmit) begin
        if (rob_sb.size() == 0) chk("rob_unexpected_grant", {20'd0, robid_out, value_out}, 32'hFFFF_FFFF);
        else begin
          re = rob_sb.pop_front();
          chk("rob_beat", {4'd0, robid_out, flags_out, wbs_out, value_out}, {4'd0, re});
        end
      end else begin
        chk("rob_idle_zero", {4'd0, robid_out, flags_out, wbs_out, value_out}, 32'd0);
      end
      if (cdb_transmit_out && !cdb_transmit) begin
        if (cdb_sb.size() == 0) chk("cdb_unexpected_grant", {20'd0, cdb_id, cdb_val}, 32'hFFFF_FFFF);
        else begin
          ce = cdb_sb.pop_front();
          chk("cdb_beat", {20'd0, cdb_id, cdb_val}, {20'd0, ce});
        end
      end else begin
        chk("cdb_idle_zero", {20'd0, cdb_id, cdb_val}, 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_cdb_en = 1'b0;
    in_wbs = '0; in_flags = '0; in_robid = '0; in_result = '0;
    cdb_transmit = 1'b0; rob_transmit = 1'b0;
    cyc(); cyc();
    smp();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_cdb_payload", {cdb_id, cdb_val}, 0);
    chk("rst_rob_payload", {robid_out, flags_out, wbs_out, value_out}, 0);
    cyc(); rst = 1'b0; cdb_transmit = 1'b1;
    smp();
    chk("idle_cdb_tx_passthru", cdb_transmit_out, 1);
    chk("idle_rob_tx_passthru", rob_transmit_out, 0);

    // T1: single result, buses free
    cyc(); cdb_transmit = 1'b0; put(1'b1, 8'h03, 8'h81, 4'd2, 8'h5A, 1, 1);
    smp();
    chk("t1_cdb_req_same", cdb_transmit_out, BYP);
    chk("t1_cdb_val_same", cdb_val, BYP ? 8'h5A : 8'h00);
    chk("t1_robid_same", robid_out, BYP ? 4'd2 : 4'd0);
    cyc(); in_valid = 1'b0;
    smp();
    chk("t1_busy_next", busy, !BYP);
    chk("t1_cdb_id_next", cdb_id, BYP ? 4'd0 : 4'd3);
    chk("t1_robid_next", robid_out, BYP ? 4'd0 : 4'd2);
    cyc(); smp();
    chk("t1_busy_idle", busy, 0);

    // T2: CDB held by upstream for 3 cycles, two results
    cyc(); cdb_transmit = 1'b1; put(1'b1, 8'h15, 8'h02, 4'd5, 8'h11, 1, 1); smp();
    cyc(); put(1'b1, 8'h16, 8'h03, 4'd6, 8'h22, 1, 1); smp();
    cyc(); in_valid = 1'b0; smp();
    chk("t2_cdb_blocked", cdb_val, 0);
    chk("t2_busy_blocked", busy, 1);
    cyc(); cdb_transmit = 1'b0; smp();
    chk("t2_cdb_first", {cdb_id, cdb_val}, {4'd5, 8'h11});
    cyc(); smp();
    chk("t2_cdb_second", {cdb_id, cdb_val}, {4'd6, 8'h22});
    cyc(); smp();
    chk("t2_busy_done", busy, 0);

    // T3: fill to DEPTH with both buses held, 5th is dropped
    cyc(); cdb_transmit = 1'b1; rob_transmit = 1'b1;
    for (int i = 0; i < 5; i++) begin
      put(1'b1, 8'h20 + 8'(i), 8'h40 + 8'(i), 4'(8 + i), 8'hA0 + 8'(i), i < 4, i < 4);
      smp();
      chk("t3_in_ready", in_ready, i < 4);
      cyc();
    end
    in_valid = 1'b0; rob_transmit = 1'b0;
    smp();
    chk("t3_overflow_set", overflow, 1);
    chk("t3_still_full", in_ready, 0);
    for (int i = 0; i < 3; i++) begin cyc(); smp(); end
    cyc(); cdb_transmit = 1'b0; smp();
    chk("t3_full_until_cdb", in_ready, 0);
    cyc(); smp();
    chk("t3_ready_after_cdb", in_ready, 1);
    cyc(); smp(); cyc(); smp();
    cyc(); smp();
    chk("t3_busy_done", busy, 0);
    chk("t3_overflow_sticky", overflow, 1);

    // T4: cdb_en pattern 1,0,1 with CDB blocked then released
    cyc(); cdb_transmit = 1'b1; put(1'b1, 8'h31, 8'h05, 4'd1, 8'hC1, 1, 1); smp();
    cyc(); put(1'b0, 8'h32, 8'h06, 4'd2, 8'hC2, 1, 0); smp();
    cyc(); put(1'b1, 8'h33, 8'h07, 4'd3, 8'hC3, 1, 1); smp();
    cyc(); in_valid = 1'b0; cdb_transmit = 1'b0; smp();
    chk("t4_cdb_e0", {cdb_id, cdb_val}, {4'd1, 8'hC1});
    cyc(); smp();
    chk("t4_skip_no_req", cdb_transmit_out, 0);
    cyc(); smp();
    chk("t4_cdb_e2", {cdb_id, cdb_val}, {4'd3, 8'hC3});
    cyc(); smp();
    chk("t4_busy_done", busy, 0);

    // T5: flush with 3 queued and a same-cycle input
    cyc(); cdb_transmit = 1'b1; rob_transmit = 1'b1;
    put(1'b1, 8'h41, 8'h00, 4'd4, 8'hD1, 0, 0); smp();
    cyc(); put(1'b1, 8'h42, 8'h00, 4'd5, 8'hD2, 0, 0); smp();
    cyc(); put(1'b1, 8'h43, 8'h00, 4'd6, 8'hD3, 0, 0); smp();
    cyc(); flush = 1'b1; put(1'b1, 8'h44, 8'h00, 4'd7, 8'hD4, 0, 0); smp();
    cyc(); flush = 1'b0; in_valid = 1'b0; cdb_transmit = 1'b0; rob_transmit = 1'b0;
    smp();
    chk("t5_busy", busy, 0);
    chk("t5_in_ready", in_ready, 1);
    chk("t5_no_cdb_req", cdb_transmit_out, 0);
    chk("t5_no_rob_req", rob_transmit_out, 0);
    chk("t5_overflow_kept", overflow, 1);
    for (int i = 0; i < 3; i++) begin cyc(); smp(); end

    // T6: reset mid-drain with 2 entries still pending
    cyc(); cdb_transmit = 1'b1; rob_transmit = 1'b1;
    put(1'b1, 8'h51, 8'h09, 4'd1, 8'hE1, 1, 1); smp();
    cyc(); put(1'b1, 8'h52, 8'h0A, 4'd2, 8'hE2, 0, 0); smp();
    cyc(); put(1'b1, 8'h53, 8'h0B, 4'd3, 8'hE3, 0, 0); smp();
    cyc(); in_valid = 1'b0; cdb_transmit = 1'b0; rob_transmit = 1'b0; smp();
    cyc(); cdb_transmit = 1'b1; rob_transmit = 1'b1; rst = 1'b1; smp();
    cyc(); rst = 1'b0; cdb_transmit = 1'b0; rob_transmit = 1'b0;
    smp();
    chk("t6_in_ready", in_ready, 1);
    chk("t6_busy", busy, 0);
    chk("t6_overflow_cleared", overflow, 0);
    chk("t6_cdb_tx_out", cdb_transmit_out, 0);
    chk("t6_rob_tx_out", rob_transmit_out, 0);
    for (int i = 0; i < 4; i++) begin cyc(); smp(); end

    chk("end_rob_sb_empty", rob_sb.size(), 0);
    chk("end_cdb_sb_empty", cdb_sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
